pic_progmem_loader: RTL and testbench
=====================================

// Module: pic_progmem_loader
// PURPOSE
//  Bus master directly upstream of the PIC wrapper's host port; replaces CPU-driven firmware upload.
//  On start: holds PIC in reset, copies N 14-bit words from a 1-cycle-latency source RAM into PIC progmem, then releases reset.
//  Sits between the SoC source buffer and the PIC wrapper (address/data_in/wen/ren/ready).
// PARAMETERS
//  WORDS_MAX  1024  max words copied; PIC progmem depth
//  SRC_AW     10    source RAM address width
//  TIMEOUT    255   max cycles to wait for pic_ready per transaction (8-bit counter)
// PORTS
//  clk          in   1    system clock
//  reset_n      in   1    asynchronous reset, active low
//  start        in   1    1-cycle pulse: begin load; ignored while busy
//  word_count   in   11   words to copy; values >WORDS_MAX saturate to WORDS_MAX
//  src_addr     out  SRC_AW  source RAM word address
//  src_rd       out  1    source read strobe; src_data valid exactly 1 cycle later
//  src_data     in   16   source word; only [13:0] used
//  pic_address  out  16   PIC host address: 0x0000 = ctl reg, 0x8000|(idx<<2) = progmem word idx
//  pic_data_in  out  32   PIC host write data
//  pic_wen      out  1    PIC host write strobe
//  pic_ren      out  1    PIC host read strobe
//  pic_data_out in   32   PIC host read data
//  pic_ready    in   1    PIC host transaction complete
//  busy         out  1    high from accepted start until done/error
//  done         out  1    1-cycle pulse: load finished, PIC released
//  error        out  1    sticky until next accepted start: timeout or verify mismatch
//  err_idx      out  10   word index at which the error occurred
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0.
//  FSM: IDLE -> HALT -> {FETCH -> WRITE [-> VERIFY]} x N -> RELEASE -> DONE -> IDLE; any bus state -> ERR on timeout.
//  IDLE: start=1 latches count (saturated), idx=0, clears error/err_idx, sets busy next cycle.
//  HALT: write ctl reg, pic_data_in=32'h1 (pic_reset=1, int0=0).
//  FETCH: src_rd=1 for 1 cycle with src_addr=idx; register src_data on the following cycle.
//  WRITE: pic_address=16'h8000|{idx,2'b00}; pic_data_in={18'h0,src_data[13:0]}.
//  RELEASE: write ctl reg, pic_data_in=32'h0; DONE: done=1 for 1 cycle, busy=0 same cycle.
//  Bus handshake: address/data/strobe held stable until pic_ready=1 is sampled; strobe drops the following cycle.
//   Exactly one of pic_wen/pic_ren is high at a time; each strobe is low for >=1 cycle between transactions.
//   pic_ready sampled only while a strobe is asserted; stray pic_ready ignored.
//  Timeout: wait counter resets at strobe rise; reaching TIMEOUT without pic_ready -> strobe low, ERR.
//  ERR: error=1, err_idx=idx (0 for ctl-reg transactions), busy=0, PIC left in reset, return to IDLE.
//  word_count=0: HALT then RELEASE directly, no FETCH; done pulses.
//  idx counts 0..count-1; last word at idx=count-1 (1023 for full load); idx never wraps.
//  start while busy: ignored, no effect on the load in progress.
//  reset_n low mid-load: all outputs drop immediately; PIC reset state is whatever the wrapper holds.
// CONFIGURATION
//  PIC_LOADER_VERIFY_EN defined: after each WRITE, VERIFY reads back the same address (pic_ren).
//   pic_data_out[13:0] != written word -> ERR with err_idx=idx.
//  PIC_LOADER_VERIFY_EN undefined: no VERIFY state; pic_ren tied 0; FSM goes WRITE -> FETCH or RELEASE.
// TESTING
//  1 count=4, src={0x3FFF,0x0001,0x2A55,0xC123}; ready 1 cycle after strobe
//    -> progmem 0..3 = 0x3FFF,0x0001,0x2A55,0x0123; ctl writes 1 then 0; one done pulse; error=0.
//  2 count=0 -> exactly two ctl writes (1, then 0); no src_rd; done pulses; busy high >=2 cycles.
//  3 count=2000 -> 1024 writes, last address 0x8FFC; no write to 0x9000.
//  4 pic_ready held low on 3rd word write -> strobe dropped after 255 cycles; error=1, err_idx=2; no RELEASE write.
//  5 start pulsed again mid-load; then reset_n low mid-load
//    -> restart ignored; on reset all outputs 0 and FSM in IDLE.
//  6 VERIFY_EN: model corrupts readback of word 1 -> error=1, err_idx=1, busy=0.
//    Without the macro, pic_ren is never asserted.

Source files
------------

// File: rtl/pic_progmem_loader.sv
// pic_progmem_loader
//   Bus master that uploads PIC firmware from a source RAM into the PIC
//   wrapper's program memory through its host port. On start it holds the
//   PIC in reset (ctl reg = 1), copies word_count 14-bit words, then writes
//   ctl reg = 0 to release it.
//
//   Optional feature: define PIC_LOADER_VERIFY_EN to read back each word
//   after writing it and flag a mismatch. Without it pic_ren is tied low.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   start, word_count load request pulse and word count (saturated to WORDS_MAX)
//   src_addr, src_rd  source RAM read port (1-cycle read latency)
//   src_data          source RAM read data, bits [13:0] used
//   pic_address, pic_data_in, pic_wen, pic_ren, pic_data_out, pic_ready
//                     PIC wrapper host port
//   busy, done        load in progress / 1-cycle completion pulse
//   error, err_idx    sticky failure flag and failing word index
module pic_progmem_loader #(
   parameter int WORDS_MAX = 1024,
   parameter int SRC_AW    = 10,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [10:0]       word_count,
   output logic [SRC_AW-1:0] src_addr,
   output logic              src_rd,
   input  logic [15:0]       src_data,
   output logic [15:0]       pic_address,
   output logic [31:0]       pic_data_in,
   output logic              pic_wen,
   output logic              pic_ren,
   input  logic [31:0]       pic_data_out,
   input  logic              pic_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [9:0]        err_idx
);

   localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [10:0] CNT_MAX  = 11'(WORDS_MAX);

   typedef enum logic [3:0] {
      S_IDLE, S_HALT, S_FETCH, S_RDWAIT, S_CAPTURE,
      S_WRITE, S_VERIFY, S_RELEASE, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [9:0]        idx_q, idx_d;
   logic [10:0]       count_q, count_d;
   logic [13:0]       word_q, word_d;
   logic [7:0]        wait_q, wait_d;
   logic [SRC_AW-1:0] src_addr_q, src_addr_d;
   logic              src_rd_q, src_rd_d;
   logic [15:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wen_q, wen_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [9:0]        err_idx_q, err_idx_d;

   logic              strobe, bus_state, bus_ack, last_word;
   logic [15:0]       wr_addr, tgt_addr;
   logic [31:0]       tgt_data;
   logic              tgt_rd;

`ifdef PIC_LOADER_VERIFY_EN
   logic              ren_q, ren_d;
   assign strobe  = wen_q | ren_q;
   assign pic_ren = ren_q;
`else
   assign strobe  = wen_q;
   assign pic_ren = 1'b0;
`endif

   // Only [13:0] of the source word and PIC readback carry firmware bits.
   logic unused_bits;
   assign unused_bits = ^{pic_data_out, src_data[15:14]};

   assign bus_state = (state_q == S_HALT) || (state_q == S_WRITE) ||
                      (state_q == S_VERIFY) || (state_q == S_RELEASE);
   assign wr_addr   = 16'h8000 | 16'({idx_q, 2'b00});
   assign last_word = (({1'b0, idx_q} + 11'd1) == count_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      count_d    = count_q;
      word_d     = word_q;
      wait_d     = wait_q;
      src_addr_d = src_addr_q;
      src_rd_d   = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wen_d      = wen_q;
`ifdef PIC_LOADER_VERIFY_EN
      ren_d      = ren_q;
`endif
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;
      err_idx_d  = err_idx_q;
      bus_ack    = 1'b0;
      tgt_addr   = 16'h0000;
      tgt_data   = 32'h0;
      tgt_rd     = 1'b0;

      case (state_q)
         S_HALT:   tgt_data = 32'h1;
         S_WRITE:  begin tgt_addr = wr_addr; tgt_data = {18'h0, word_q}; end
         S_VERIFY: begin tgt_addr = wr_addr; tgt_data = {18'h0, word_q}; tgt_rd = 1'b1; end
         default:  ;
      endcase

      // Shared handshake: every bus state enters with the strobe low, so the
      // first cycle of a state is the mandatory low gap before raising it.
      if (bus_state) begin
         if (!strobe) begin
            addr_d  = tgt_addr;
            wdata_d = tgt_data;
            wen_d   = !tgt_rd;
`ifdef PIC_LOADER_VERIFY_EN
            ren_d   = tgt_rd;
`endif
            wait_d  = 8'd0;
         end else if (pic_ready) begin
            wen_d   = 1'b0;
`ifdef PIC_LOADER_VERIFY_EN
            ren_d   = 1'b0;
`endif
            bus_ack = 1'b1;
         end else if (wait_q == TMO_LAST) begin
            wen_d     = 1'b0;
`ifdef PIC_LOADER_VERIFY_EN
            ren_d     = 1'b0;
`endif
            error_d   = 1'b1;
            err_idx_d = (state_q == S_WRITE || state_q == S_VERIFY) ? idx_q : 10'd0;
            busy_d    = 1'b0;
            state_d   = S_ERR;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end

      case (state_q)
         S_IDLE: if (start) begin
            count_d   = (word_count > CNT_MAX) ? CNT_MAX : word_count;
            idx_d     = 10'd0;
            error_d   = 1'b0;
            err_idx_d = 10'd0;
            busy_d    = 1'b1;
            state_d   = S_HALT;
         end
         S_HALT: if (bus_ack) state_d = (count_q == 11'd0) ? S_RELEASE : S_FETCH;
         S_FETCH: begin
            src_rd_d   = 1'b1;
            src_addr_d = SRC_AW'(idx_q);
            state_d    = S_RDWAIT;
         end
         S_RDWAIT:  state_d = S_CAPTURE;   // src_rd visible this cycle
         S_CAPTURE: begin                  // RAM data valid this cycle
            word_d  = src_data[13:0];
            state_d = S_WRITE;
         end
`ifdef PIC_LOADER_VERIFY_EN
         S_WRITE: if (bus_ack) state_d = S_VERIFY;
         S_VERIFY: if (bus_ack) begin
            if (pic_data_out[13:0] != word_q) begin
               error_d   = 1'b1;
               err_idx_d = idx_q;
               busy_d    = 1'b0;
               state_d   = S_ERR;
            end else if (last_word) begin
               state_d = S_RELEASE;
            end else begin
               idx_d   = idx_q + 10'd1;
               state_d = S_FETCH;
            end
         end
`else
         S_WRITE: if (bus_ack) begin
            if (last_word) begin
               state_d = S_RELEASE;
            end else begin
               idx_d   = idx_q + 10'd1;
               state_d = S_FETCH;
            end
         end
`endif
         S_RELEASE: if (bus_ack) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         count_q    <= '0;
         word_q     <= '0;
         wait_q     <= '0;
         src_addr_q <= '0;
         src_rd_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wen_q      <= 1'b0;
`ifdef PIC_LOADER_VERIFY_EN
         ren_q      <= 1'b0;
`endif
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         word_q     <= word_d;
         wait_q     <= wait_d;
         src_addr_q <= src_addr_d;
         src_rd_q   <= src_rd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wen_q      <= wen_d;
`ifdef PIC_LOADER_VERIFY_EN
         ren_q      <= ren_d;
`endif
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_idx_q  <= err_idx_d;
      end
   end

   assign src_addr    = src_addr_q;
   assign src_rd      = src_rd_q;
   assign pic_address = addr_q;
   assign pic_data_in = wdata_q;
   assign pic_wen     = wen_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_pic_progmem_loader.sv
// Testbench for pic_progmem_loader: source RAM and PIC host-port models,
// a reference model that lists the expected host transactions per load,
// and a monitor that pops and compares each completed transaction.
`timescale 1ns/1ps
module tb_pic_progmem_loader;

`ifdef PIC_LOADER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int TMO = 255;

   logic        clk = 1'b0, reset_n = 1'b1, start = 1'b0;
   logic [10:0] word_count = '0;
   logic [9:0]  src_addr;
   logic        src_rd;
   logic [15:0] src_data = '0;
   logic [15:0] pic_address;
   logic [31:0] pic_data_in;
   logic        pic_wen, pic_ren;
   logic [31:0] pic_data_out = '0;
   logic        pic_ready = 1'b0;
   logic        busy, done, error;
   logic [9:0]  err_idx;

   pic_progmem_loader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
      .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
      .pic_address(pic_address), .pic_data_in(pic_data_in),
      .pic_wen(pic_wen), .pic_ren(pic_ren), .pic_data_out(pic_data_out),
      .pic_ready(pic_ready), .busy(busy), .done(done), .error(error),
      .err_idx(err_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_q[$];
   int          n_checks = 0, n_err = 0;
   logic [15:0] src_mem [0:1023];
   logic [31:0] pm [0:1023];
   int          lat = 1;
   bit          hold_en = 0, corrupt_en = 0;
   int          hold_idx = 0, corrupt_idx = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endfunction

   function automatic void push_txn(logic we, logic [15:0] a, logic [31:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.data = d;
      exp_q.push_back(t);
   endfunction

   // Reference: the host-port transactions a load of wc words must produce.
   function automatic void push_model(int wc, output logic e_err, output logic [9:0] e_idx);
      int n;
      n = (wc > 1024) ? 1024 : wc;
      e_err = 1'b0; e_idx = '0;
      push_txn(1'b1, 16'h0000, 32'h1);
      for (int i = 0; i < n; i++) begin
         if (hold_en && i == hold_idx) begin e_err = 1'b1; e_idx = 10'(i); return; end
         push_txn(1'b1, 16'h8000 + 16'(i * 4), {18'h0, src_mem[i][13:0]});
         if (VERIFY) begin
            push_txn(1'b0, 16'h8000 + 16'(i * 4), 32'h0);
            if (corrupt_en && i == corrupt_idx) begin e_err = 1'b1; e_idx = 10'(i); return; end
         end
      end
      push_txn(1'b1, 16'h0000, 32'h0);
   endfunction

   // Source RAM: one-cycle read latency.
   always @(posedge clk) if (src_rd) src_data <= src_mem[src_addr];

   // PIC host port: acknowledge after lat strobe cycles unless held off.
   int hcnt = 0;
   always @(posedge clk) begin
      int a;
      logic [13:0] v;
      #1;
      if (!(pic_wen || pic_ren)) begin
         pic_ready = 1'b0;
         hcnt = 0;
      end else if (!pic_ready) begin
         hcnt++;
         if (hcnt >= lat && !(hold_en && pic_wen && pic_address == 16'h8000 + 16'(hold_idx * 4))) begin
            pic_ready = 1'b1;
            a = (int'(pic_address) - 32'h8000) >>> 2;
            if (pic_wen) begin
               if (pic_address[15] && a >= 0 && a < 1024) pm[a] = pic_data_in;
            end else if (a >= 0 && a < 1024) begin
               v = pm[a][13:0];
               if (corrupt_en && a == corrupt_idx) v = v ^ 14'h0004;
               pic_data_out = {18'($urandom), v};
            end
         end
      end
   end

   // Monitor: compares every completed transaction against the scoreboard.
   int          done_tot = 0, rd_tot = 0, busy_tot = 0, hi_run = 0, last_run = 0;
   bit          prev_ack = 0, ren_seen = 0;
   logic [15:0] last_pm_addr = '0;
   always @(negedge clk) begin
      logic stb;
      txn_t e;
      stb = pic_wen | pic_ren;
      chk("one_strobe", {31'h0, pic_wen & pic_ren}, 32'h0);
      if (prev_ack) chk("strobe_gap", {31'h0, stb}, 32'h0);
      prev_ack = stb && pic_ready;
      if (stb && pic_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_txn_addr", {16'h0, pic_address}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("txn_wen", {31'h0, pic_wen}, {31'h0, e.we});
            chk("txn_addr", {16'h0, pic_address}, {16'h0, e.addr});
            if (e.we) chk("txn_data", pic_data_in, e.data);
         end
         if (pic_wen && pic_address[15]) last_pm_addr = pic_address;
      end
      if (done) begin
         done_tot++;
         chk("done_with_busy_low", {31'h0, busy}, 32'h0);
      end
      if (src_rd) rd_tot++;
      if (pic_ren) ren_seen = 1;
      if (busy) busy_tot++;
      if (stb) hi_run++;
      else begin
         if (hi_run != 0) last_run = hi_run;
         hi_run = 0;
      end
   end

   int base_done, base_rd, base_busy;

   task automatic run_load(input int wc, output logic e_err, output logic [9:0] e_idx);
      int k;
      push_model(wc, e_err, e_idx);
      base_done = done_tot; base_rd = rd_tot; base_busy = busy_tot;
      @(posedge clk); #1; word_count = 11'(wc); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("busy_after_start", {31'h0, busy}, 32'h1);
      chk("error_cleared_on_start", {31'h0, error}, 32'h0);
      k = 0;
      while (busy && k < 20000) begin @(negedge clk); k++; end
      chk("load_ends_in_budget", {31'h0, busy}, 32'h0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'h0);
      chk("error", {31'h0, error}, {31'h0, e_err});
      chk("err_idx", {22'h0, err_idx}, {22'h0, e_idx});
      chk("done_pulses", done_tot - base_done, e_err ? 32'h0 : 32'h1);
   endtask

   initial begin
      logic       e_err;
      logic [9:0] e_idx;
      int         n;
      for (int i = 0; i < 1024; i++) begin src_mem[i] = 16'($urandom); pm[i] = '0; end

      #2 reset_n = 1'b0;
      #1 chk("reset_outputs_zero", {31'h0, |{src_addr, src_rd, pic_address, pic_data_in, pic_wen,
                                              pic_ren, busy, done, error, err_idx}}, 32'h0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // 1: four words, including bits above [13:0] that must be dropped
      src_mem[0] = 16'h3FFF; src_mem[1] = 16'h0001; src_mem[2] = 16'h2A55; src_mem[3] = 16'hC123;
      lat = 1;
      run_load(4, e_err, e_idx);
      chk("pm0", pm[0], 32'h3FFF);
      chk("pm1", pm[1], 32'h0001);
      chk("pm2", pm[2], 32'h2A55);
      chk("pm3", pm[3], 32'h0123);
      chk("src_reads_4", rd_tot - base_rd, 32'd4);

      // 2: zero words
      run_load(0, e_err, e_idx);
      chk("src_reads_0", rd_tot - base_rd, 32'd0);
      chk("busy_len_ge2", {31'h0, (busy_tot - base_busy) >= 2}, 32'h1);

      // random loads
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 32; i++) src_mem[i] = 16'($urandom);
         lat = $urandom_range(1, 4);
         n = $urandom_range(1, 24);
         run_load(n, e_err, e_idx);
         chk("src_reads_rand", rd_tot - base_rd, n);
      end

      // 3: saturated full load
      lat = 1;
      for (int i = 0; i < 1024; i++) src_mem[i] = 16'($urandom);
      run_load(2000, e_err, e_idx);
      chk("src_reads_full", rd_tot - base_rd, 32'd1024);
      chk("last_pm_addr", {16'h0, last_pm_addr}, 32'h8FFC);
      chk("pm1023", pm[1023], {18'h0, src_mem[1023][13:0]});

      // 4: third word write never acknowledged
      lat = $urandom_range(1, 3);
      hold_en = 1; hold_idx = 2;
      run_load(6, e_err, e_idx);
      chk("timeout_strobe_cycles", last_run, TMO);
      chk("busy_after_timeout", {31'h0, busy}, 32'h0);
      hold_en = 0;
      run_load(3, e_err, e_idx);

      // 5: restart ignored while busy, then reset mid-load
      lat = 2;
      push_model(30, e_err, e_idx);
      @(posedge clk); #1; word_count = 11'd30; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (40) @(posedge clk);
      #1; word_count = 11'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (30) @(posedge clk);
      #1 chk("busy_mid_load", {31'h0, busy}, 32'h1);
      #2 reset_n = 1'b0;
      #1 chk("midload_reset_outputs_zero", {31'h0, |{src_addr, src_rd, pic_address, pic_data_in,
                                              pic_wen, pic_ren, busy, done, error, err_idx}}, 32'h0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_after_reset", {30'h0, busy, pic_wen | pic_ren}, 32'h0);
      end
      run_load(5, e_err, e_idx);

      // 6: readback mismatch (verify build) / no reads at all (default build)
      if (VERIFY) begin
         corrupt_en = 1; corrupt_idx = 1;
         run_load(4, e_err, e_idx);
         chk("verify_err_idx", {22'h0, err_idx}, 32'd1);
         chk("verify_busy", {31'h0, busy}, 32'h0);
         corrupt_en = 0;
      end else begin
         chk("pic_ren_never", {31'h0, ren_seen}, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
